// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the serial ALU output path: frame type bits,
// CRC3 polynomial, flag bit positions, packet sizing and serializer states.
// Optional feature macro: MTM_ALU_SER_GAP_EN (adds the GAP state).
package mtm_alu_pkg;

  // Frame type bit carried right after the start bit
  localparam logic FRAME_DATA = 1'b0;
  localparam logic FRAME_CTL  = 1'b1;

  // CRC3 generator x^3 + x + 1 (implicit x^3 term)
  localparam logic [2:0] CRC3_POLY = 3'b011;

  // CRC input is {C, 1'b0, flags}
  localparam int unsigned CRC_IN_W = 37;

  // Positions inside the 4-bit flags word {carry, overflow, zero, negative}
  localparam int unsigned FLAG_CARRY    = 3;
  localparam int unsigned FLAG_OVERFLOW = 2;
  localparam int unsigned FLAG_ZERO     = 1;
  localparam int unsigned FLAG_NEGATIVE = 0;

  // Four data frames plus one control frame per result packet
  localparam int unsigned NUM_RESULT_FRAMES = 5;

  // Serializer states; each non-idle state names the bit currently on sout
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TYPE,
    ST_DATA,
`ifdef MTM_ALU_SER_GAP_EN
    ST_STOP,
    ST_GAP
`else
    ST_STOP
`endif
  } ser_state_t;

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC3 (x^3 + x + 1, init 000) over a 37-bit vector, MSB first.
module mtm_alu_crc3
  import mtm_alu_pkg::*;
(
  input  logic [CRC_IN_W-1:0] data,
  output logic [2:0]          crc
);

  logic [2:0] acc;
  logic       fb;

  // Bit-serial LFSR unrolled over the whole input vector
  always_comb begin
    acc = '0;
    fb  = 1'b0;
    for (int unsigned i = 0; i < CRC_IN_W; i++) begin
      fb  = acc[2] ^ data[CRC_IN_W-1-i];
      acc = {acc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
    end
    crc = acc;
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Output stage of the serial ALU: captures one result (C + flags, with CRC3)
// or one error control byte and shifts it out MSB-first as 11-bit frames
// {start 0, type, data[7:0], stop 1}. Line idles high.
// Optional feature macro: MTM_ALU_SER_GAP_EN inserts GAP_BITS idle-high bits
// after every stop bit.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int unsigned GAP_BITS = 2
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        err_in,
  input  logic [31:0] C_in,
  input  logic [3:0]  flags_in,
  input  logic [7:0]  err_frame_in,
  output logic        ready_out,
  output logic        sout
);

  localparam logic [2:0] LAST_RESULT_FRAME = 3'(NUM_RESULT_FRAMES - 1);

  ser_state_t  state;
  logic [39:0] shreg;
  logic [2:0]  bit_cnt;
  logic [2:0]  frame_cnt;
  logic        is_err;
  logic [2:0]  crc;
  logic [7:0]  ctl_byte;
  logic        last_frame;
  logic        frame_type;

`ifdef MTM_ALU_SER_GAP_EN
  localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  logic [GAP_W-1:0] gap_cnt;
`endif

  mtm_alu_crc3 u_crc3 (
    .data ({C_in, 1'b0, flags_in}),
    .crc  (crc)
  );

  assign ctl_byte = {1'b0, flags_in[FLAG_CARRY], flags_in[FLAG_OVERFLOW],
                     flags_in[FLAG_ZERO], flags_in[FLAG_NEGATIVE], crc};

  // Terminal frame is decoded explicitly so the frame counter never wraps
  assign last_frame = is_err ? (frame_cnt == 3'd0) : (frame_cnt == LAST_RESULT_FRAME);
  assign frame_type = (is_err || (frame_cnt == LAST_RESULT_FRAME)) ? FRAME_CTL : FRAME_DATA;

  // Packet FSM with registered sout/ready_out; state names the bit on sout
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sout      <= 1'b1;
      ready_out <= 1'b1;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      shreg     <= '0;
      is_err    <= 1'b0;
`ifdef MTM_ALU_SER_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_in && ready_out) begin
            ready_out <= 1'b0;
            sout      <= 1'b0;
            state     <= ST_START;
            frame_cnt <= '0;
            is_err    <= err_in;
            shreg     <= err_in ? {err_frame_in, 32'h0} : {C_in, ctl_byte};
          end
        end
        ST_START: begin
          sout  <= frame_type;
          state <= ST_TYPE;
        end
        ST_TYPE: begin
          sout    <= shreg[39];
          shreg   <= {shreg[38:0], 1'b0};
          bit_cnt <= 3'd7;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt == 3'd0) begin
            sout  <= 1'b1;
            state <= ST_STOP;
          end else begin
            sout    <= shreg[39];
            shreg   <= {shreg[38:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
`ifdef MTM_ALU_SER_GAP_EN
        ST_STOP: begin
          sout    <= 1'b1;
          gap_cnt <= GAP_W'(GAP_BITS - 1);
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (last_frame) begin
            state     <= ST_IDLE;
            ready_out <= 1'b1;
            sout      <= 1'b1;
            frame_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + 3'd1;
            sout      <= 1'b0;
            state     <= ST_START;
          end
        end
`else
        ST_STOP: begin
          if (last_frame) begin
            state     <= ST_IDLE;
            ready_out <= 1'b1;
            sout      <= 1'b1;
            frame_cnt <= '0;
          end else begin
            frame_cnt <= frame_cnt + 3'd1;
            sout      <= 1'b0;
            state     <= ST_START;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          sout      <= 1'b1;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
